// File: rtl/bufrx_sched_pkg.sv
// Shared FSM state encoding and default sizing constants for the RX buffer event scheduler.
package bufrx_sched_pkg;

  localparam int unsigned C_MAX_UDP_PORTS_DEF    = 1024;
  localparam int unsigned C_PORT_INDEX_WIDTH_DEF = 10;
  localparam int unsigned C_COAL_TIMER_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OFFER = 2'd2
  } sched_state_e;

endpackage

// File: rtl/bufrx_irq_coalescer.sv
// Interrupt generation from the pending-port count. With BUFRX_IRQ_COALESCE_EN defined the
// interrupt is coalesced by count threshold and timeout; otherwise it tracks pending_cnt_i != 0.
module bufrx_irq_coalescer
  import bufrx_sched_pkg::*;
#(
  parameter int unsigned C_PORT_INDEX_WIDTH = C_PORT_INDEX_WIDTH_DEF,
  parameter int unsigned C_COAL_TIMER_WIDTH = C_COAL_TIMER_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [C_PORT_INDEX_WIDTH:0]   pending_cnt_i,
  input  logic [C_PORT_INDEX_WIDTH:0]   coal_thresh_i,
  input  logic [C_COAL_TIMER_WIDTH-1:0] coal_timeout_i,
  output logic                          irq_o
);

  logic irq_q;
  logic cnt_nz;

  always_comb cnt_nz = (pending_cnt_i != '0);

`ifdef BUFRX_IRQ_COALESCE_EN
  localparam logic [C_PORT_INDEX_WIDTH:0] THRESH_MIN = 1;

  logic [C_COAL_TIMER_WIDTH-1:0] timer_q;
  logic [C_PORT_INDEX_WIDTH:0]   thresh_eff;

  always_comb thresh_eff = (coal_thresh_i == '0) ? THRESH_MIN : coal_thresh_i;

  // Timer saturates at the timeout; irq latches until the pending count drains to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
      irq_q   <= 1'b0;
    end else if (!cnt_nz) begin
      timer_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (timer_q != coal_timeout_i) timer_q <= timer_q + 1'b1;
      if ((pending_cnt_i >= thresh_eff) || (timer_q == coal_timeout_i)) irq_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  always_comb unused_cfg = ^{coal_thresh_i, coal_timeout_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= cnt_nz;
  end
`endif

  assign irq_o = irq_q;

endmodule

// File: rtl/bufrx_event_scheduler.sv
// Round-robin event scheduler over per-port RX socket buffers; offers one pending port at a time.
// Interrupt coalescing is selected with the BUFRX_IRQ_COALESCE_EN macro (see bufrx_irq_coalescer).
module bufrx_event_scheduler
  import bufrx_sched_pkg::*;
#(
  parameter int unsigned C_MAX_UDP_PORTS    = C_MAX_UDP_PORTS_DEF,
  parameter int unsigned C_PORT_INDEX_WIDTH = C_PORT_INDEX_WIDTH_DEF,
  parameter int unsigned C_COAL_TIMER_WIDTH = C_COAL_TIMER_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [C_MAX_UDP_PORTS-1:0]    bufrx_pushed_i,
  input  logic [C_MAX_UDP_PORTS-1:0]    bufrx_opensock_i,
  input  logic                          enable_i,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [C_PORT_INDEX_WIDTH-1:0] evt_port_o,
  output logic [C_PORT_INDEX_WIDTH:0]   pending_cnt_o,
  input  logic [C_PORT_INDEX_WIDTH:0]   coal_thresh_i,
  input  logic [C_COAL_TIMER_WIDTH-1:0] coal_timeout_i,
  output logic                          irq_o
);

  localparam logic [C_PORT_INDEX_WIDTH-1:0] LAST_PORT = C_PORT_INDEX_WIDTH'(C_MAX_UDP_PORTS - 1);

  sched_state_e                  state_q;
  logic [C_MAX_UDP_PORTS-1:0]    pending_q, pending_d;
  logic [C_PORT_INDEX_WIDTH:0]   cnt_q, cnt_d;
  logic [C_PORT_INDEX_WIDTH-1:0] ptr_q;
  logic [C_PORT_INDEX_WIDTH-1:0] evt_port_q;
  logic                          evt_valid_q;
  logic                          handshake;

  function automatic logic [C_PORT_INDEX_WIDTH-1:0] ptr_inc(input logic [C_PORT_INDEX_WIDTH-1:0] p);
    return (p == LAST_PORT) ? '0 : p + 1'b1;
  endfunction

  always_comb handshake = evt_valid_q & evt_ready_i;

  // A push wins over a same-cycle clear so no event is lost.
  always_comb begin
    pending_d = pending_q;
    for (int unsigned i = 0; i < C_MAX_UDP_PORTS; i++) begin
      if (bufrx_pushed_i[i] && bufrx_opensock_i[i]) begin
        pending_d[i] = 1'b1;
      end else if (!bufrx_opensock_i[i] ||
                   (handshake && (evt_port_q == C_PORT_INDEX_WIDTH'(i)))) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < C_MAX_UDP_PORTS; i++) begin
      cnt_d = cnt_d + {{C_PORT_INDEX_WIDTH{1'b0}}, pending_q[i]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      evt_port_q  <= '0;
      evt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable_i && (pending_q != '0)) state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          if (!enable_i || (pending_q == '0)) begin
            state_q <= ST_IDLE;
          end else if (pending_q[ptr_q]) begin
            evt_port_q  <= ptr_q;
            evt_valid_q <= 1'b1;
            state_q     <= ST_OFFER;
          end else begin
            ptr_q <= ptr_inc(ptr_q);
          end
        end
        ST_OFFER: begin
          // Held regardless of enable_i or socket state until the host accepts.
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            ptr_q       <= ptr_inc(evt_port_q);
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          evt_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign evt_valid_o   = evt_valid_q;
  assign evt_port_o    = evt_port_q;
  assign pending_cnt_o = cnt_q;

  bufrx_irq_coalescer #(
    .C_PORT_INDEX_WIDTH (C_PORT_INDEX_WIDTH),
    .C_COAL_TIMER_WIDTH (C_COAL_TIMER_WIDTH)
  ) u_irq (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .pending_cnt_i  (cnt_q),
    .coal_thresh_i  (coal_thresh_i),
    .coal_timeout_i (coal_timeout_i),
    .irq_o          (irq_o)
  );

endmodule

// File: tb/tb_bufrx_event_scheduler.sv
// Self-checking bench for bufrx_event_scheduler (8 ports) against a per-port pending-set model.
module tb_bufrx_event_scheduler;

  localparam int N  = 8;
  localparam int W  = 3;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  push_v;
  logic [N-1:0]  open_v;
  logic          enable;
  logic          ready;
  logic          evt_valid_o;
  logic [W-1:0]  evt_port_o;
  logic [W:0]    pending_cnt_o;
  logic [W:0]    thresh;
  logic [TW-1:0] timeout;
  logic          irq_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: set of pending ports and the expected registered outputs.
  bit m_pend [N];
  int m_cnt;
  bit m_irq_exp;
  bit hs_seen;
  int hs_port;
  bit hs_was_pending;

  always #5 clk = ~clk;

  bufrx_event_scheduler #(
    .C_MAX_UDP_PORTS    (N),
    .C_PORT_INDEX_WIDTH (W),
    .C_COAL_TIMER_WIDTH (TW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .bufrx_pushed_i   (push_v),
    .bufrx_opensock_i (open_v),
    .enable_i         (enable),
    .evt_valid_o      (evt_valid_o),
    .evt_ready_i      (ready),
    .evt_port_o       (evt_port_o),
    .pending_cnt_o    (pending_cnt_o),
    .coal_thresh_i    (thresh),
    .coal_timeout_i   (timeout),
    .irq_o            (irq_o)
  );

  task automatic model_reset();
    for (int p = 0; p < N; p++) m_pend[p] = 1'b0;
    m_cnt     = 0;
    m_irq_exp = 1'b0;
    hs_seen   = 1'b0;
  endtask

  // One clock: record handshake, advance model, cross the edge, sample 1 time unit later.
  task automatic tick();
    bit hs;
    int hp;
    int pc;
    hs = (evt_valid_o === 1'b1) && (ready === 1'b1);
    hp = int'(evt_port_o);
    hs_seen = hs;
    hs_port = hp;
    hs_was_pending = hs ? m_pend[hp] : 1'b0;
    pc = 0;
    for (int p = 0; p < N; p++) if (m_pend[p]) pc++;
    m_irq_exp = (m_cnt != 0);
    m_cnt = pc;
    for (int p = 0; p < N; p++) begin
      if (push_v[p] && open_v[p]) m_pend[p] = 1'b1;
      else if (!open_v[p] || (hs && p == hp)) m_pend[p] = 1'b0;
    end
    @(posedge clk);
    #1;
    push_v = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    #1;
    n_tests++; if (evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", evt_valid_o); end
    n_tests++; if (evt_port_o !== 3'd0) begin n_fail++; $display("FAIL reset_port: got %0d expected 0", evt_port_o); end
    n_tests++; if (pending_cnt_o !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", pending_cnt_o); end
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    bit found = 0;
    int port = -1;
    open_v = '1; enable = 1'b1; ready = 1'b1;
    push_v[5] = 1'b1;
    tick();
    for (int i = 0; i < 10 && !found; i++) begin
      if (evt_valid_o === 1'b1) begin found = 1; port = int'(evt_port_o); end
      else tick();
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL single_latency: got no evt_valid expected within 10 cycles"); end
    n_tests++; if (port != 5) begin n_fail++; $display("FAIL single_port: got %0d expected 5", port); end
    repeat (3) tick();
    n_tests++; if (pending_cnt_o !== 4'd0) begin n_fail++; $display("FAIL single_cnt: got %0d expected 0", pending_cnt_o); end
  endtask

  task automatic test_round_robin();
    int ev [3];
    int n_ev = 0;
    bit repushed = 0;
    do_reset();
    ready = 1'b1; enable = 1'b1;
    push_v[2] = 1'b1; push_v[6] = 1'b1;
    tick();
    push_v[2] = 1'b1;
    tick();
    for (int c = 0; c < 60 && n_ev < 3; c++) begin
      tick();
      if (hs_seen) begin
        ev[n_ev] = hs_port;
        n_ev++;
        if (n_ev == 1 && !repushed) begin push_v[2] = 1'b1; repushed = 1; end
      end
    end
    n_tests++; if (n_ev != 3) begin n_fail++; $display("FAIL rr_count: got %0d expected 3", n_ev); end
    else begin
      n_tests++; if (ev[0] != 2) begin n_fail++; $display("FAIL rr_ev0: got %0d expected 2", ev[0]); end
      n_tests++; if (ev[1] != 6) begin n_fail++; $display("FAIL rr_ev1: got %0d expected 6", ev[1]); end
      n_tests++; if (ev[2] != 2) begin n_fail++; $display("FAIL rr_ev2: got %0d expected 2", ev[2]); end
    end
  endtask

  task automatic test_merge_close();
    int ev3 = 0;
    int ev4 = 0;
    ready = 1'b1; enable = 1'b1;
    push_v[3] = 1'b1; tick(); if (hs_seen && hs_port == 3) ev3++;
    push_v[3] = 1'b1; tick(); if (hs_seen && hs_port == 3) ev3++;
    for (int c = 0; c < 30; c++) begin tick(); if (hs_seen && hs_port == 3) ev3++; end
    n_tests++; if (ev3 != 1) begin n_fail++; $display("FAIL merge_events: got %0d expected 1", ev3); end

    enable = 1'b0;
    push_v[4] = 1'b1; tick(); tick();
    n_tests++; if (pending_cnt_o !== 4'd1) begin n_fail++; $display("FAIL close_before_cnt: got %0d expected 1", pending_cnt_o); end
    open_v[4] = 1'b0; tick();
    open_v[4] = 1'b1; enable = 1'b1;
    for (int c = 0; c < 20; c++) begin tick(); if (hs_seen && hs_port == 4) ev4++; end
    n_tests++; if (ev4 != 0) begin n_fail++; $display("FAIL close_events: got %0d expected 0", ev4); end
    n_tests++; if (pending_cnt_o !== 4'd0) begin n_fail++; $display("FAIL close_cnt: got %0d expected 0", pending_cnt_o); end
  endtask

  task automatic test_backpressure();
    bit found = 0;
    logic [W-1:0] port0;
    ready = 1'b0; enable = 1'b1;
    push_v[1] = 1'b1;
    tick();
    for (int i = 0; i < N + 4 && !found; i++) begin
      if (evt_valid_o === 1'b1) found = 1; else tick();
    end
    port0 = evt_port_o;
    n_tests++; if (!found) begin n_fail++; $display("FAIL bp_offer: got no evt_valid expected within %0d cycles", N + 4); end
    n_tests++; if (port0 !== 3'd1) begin n_fail++; $display("FAIL bp_port: got %0d expected 1", port0); end
    for (int i = 0; i < 20; i++) begin
      if (i == 3) enable = 1'b0;
      tick();
      n_tests++;
      if (evt_valid_o !== 1'b1 || evt_port_o !== port0 || hs_seen) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d got valid=%b port=%0d expected valid=1 port=%0d", i, evt_valid_o, evt_port_o, port0);
      end
    end
    ready = 1'b1;
    tick();
    n_tests++; if (!hs_seen || hs_port != 1) begin n_fail++; $display("FAIL bp_deliver: got hs=%b port=%0d expected hs=1 port=1", hs_seen, hs_port); end
    tick();
    n_tests++; if (evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drop: got %b expected 0", evt_valid_o); end
    n_tests++; if (pending_cnt_o !== 4'd0) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 0", pending_cnt_o); end
    enable = 1'b1;
  endtask

  task automatic test_random();
    int starved = 0;
    bit any;
    open_v = '1; enable = 1'b1;
    for (int c = 0; c < 400; c++) begin
      push_v = N'($urandom) & N'($urandom);
      ready  = ($urandom_range(0, 3) != 0);
      tick();
      n_tests++; if (pending_cnt_o !== 4'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt: cycle %0d got %0d expected %0d", c, pending_cnt_o, m_cnt); end
`ifndef BUFRX_IRQ_COALESCE_EN
      n_tests++; if (irq_o !== m_irq_exp) begin n_fail++; $display("FAIL rnd_irq: cycle %0d got %b expected %b", c, irq_o, m_irq_exp); end
`endif
      if (hs_seen) begin
        n_tests++; if (!hs_was_pending) begin n_fail++; $display("FAIL rnd_evt_pending: cycle %0d port %0d got not-pending expected pending", c, hs_port); end
      end
      any = 0;
      for (int p = 0; p < N; p++) if (m_pend[p]) any = 1;
      starved = (any && evt_valid_o !== 1'b1) ? starved + 1 : 0;
      n_tests++; if (starved > N + 3) begin n_fail++; $display("FAIL rnd_latency: cycle %0d got %0d idle cycles expected <= %0d", c, starved, N + 3); starved = 0; end
    end
    ready = 1'b1;
  endtask

  task automatic test_coalesce();
    int rise = -1;
    do_reset();
    enable = 1'b0; ready = 1'b0; open_v = '1;
    thresh = 4'd3; timeout = 16'd50;
`ifdef BUFRX_IRQ_COALESCE_EN
    // pending at edge 0, count visible at edge 1, timer hits 50 at edge 51, irq at edge 52.
    push_v[0] = 1'b1; push_v[1] = 1'b1;
    tick();
    for (int c = 1; c <= 70 && rise < 0; c++) begin tick(); if (irq_o === 1'b1) rise = c; end
    n_tests++; if (rise < 50 || rise > 53) begin n_fail++; $display("FAIL coal_timeout: got rise at %0d expected 50..53", rise); end
    open_v = '0; repeat (3) tick(); open_v = '1;
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL coal_clear: got %b expected 0", irq_o); end
    push_v[2] = 1'b1; push_v[3] = 1'b1; push_v[4] = 1'b1;
    tick();
    rise = -1;
    for (int c = 1; c <= 6 && rise < 0; c++) begin tick(); if (irq_o === 1'b1) rise = c; end
    n_tests++; if (rise < 1 || rise > 3) begin n_fail++; $display("FAIL coal_thresh: got rise at %0d expected 1..3", rise); end
    open_v = '0; repeat (3) tick(); open_v = '1;
    thresh = 4'd0;
    push_v[7] = 1'b1;
    tick();
    rise = -1;
    for (int c = 1; c <= 6 && rise < 0; c++) begin tick(); if (irq_o === 1'b1) rise = c; end
    n_tests++; if (rise < 1 || rise > 3) begin n_fail++; $display("FAIL coal_thresh0: got rise at %0d expected 1..3", rise); end
`else
    push_v[0] = 1'b1; push_v[1] = 1'b1;
    tick();
    for (int c = 1; c <= 6 && rise < 0; c++) begin tick(); if (irq_o === 1'b1) rise = c; end
    n_tests++; if (rise != 2) begin n_fail++; $display("FAIL irq_follow_rise: got rise at %0d expected 2", rise); end
    open_v = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++; if (irq_o !== m_irq_exp) begin n_fail++; $display("FAIL irq_follow_fall: cycle %0d got %b expected %b", c, irq_o, m_irq_exp); end
    end
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_follow_low: got %b expected 0", irq_o); end
    open_v = '1;
`endif
    open_v = '1; enable = 1'b1; ready = 1'b1;
  endtask

  task automatic test_async_reset();
    bit found = 0;
    enable = 1'b1; ready = 1'b0;
    push_v[6] = 1'b1;
    tick();
    for (int i = 0; i < N + 4 && !found; i++) begin
      if (evt_valid_o === 1'b1) found = 1; else tick();
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL arst_offer: got no evt_valid expected within %0d cycles", N + 4); end
    n_tests++; if (pending_cnt_o !== 4'd1) begin n_fail++; $display("FAIL arst_precnt: got %0d expected 1", pending_cnt_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_tests++; if (evt_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", evt_valid_o); end
    n_tests++; if (pending_cnt_o !== 4'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d expected 0", pending_cnt_o); end
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL arst_irq: got %b expected 0", irq_o); end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();
    ready = 1'b1;
    tick(); tick();
    n_tests++; if (evt_valid_o !== 1'b0 || hs_seen) begin n_fail++; $display("FAIL arst_after: got valid=%b hs=%b expected 0 0", evt_valid_o, hs_seen); end
    n_tests++; if (pending_cnt_o !== 4'd0) begin n_fail++; $display("FAIL arst_after_cnt: got %0d expected 0", pending_cnt_o); end
  endtask

  initial begin
    push_v = '0; open_v = '1; enable = 1'b1; ready = 1'b1;
    thresh = 4'd3; timeout = 16'd50;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_merge_close();
    test_backpressure();
    test_random();
    test_coalesce();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bufrx_event_scheduler.md
BUFRX_EVENT_SCHEDULER -- requirements
Module: bufrx_event_scheduler

Interface
REQ-001 Parameter C_MAX_UDP_PORTS SHALL default to 1024; it is the number of RX socket buffers served.
REQ-002 Parameter C_PORT_INDEX_WIDTH SHALL default to 10; it is the port index width, and C_MAX_UDP_PORTS SHALL be at most 2**C_PORT_INDEX_WIDTH.
REQ-003 Parameter C_COAL_TIMER_WIDTH SHALL default to 16; it is the width of the coalescing timer.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports SHALL be:
- clk_i, in, 1: clock.
- rst_ni, in, 1: async active-low reset.
- bufrx_pushed_i, in, C_MAX_UDP_PORTS: one-cycle push pulse per port.
- bufrx_opensock_i, in, C_MAX_UDP_PORTS: socket open, per port.
- enable_i, in, 1: scheduler enable.
- evt_valid_o, out, 1: event offered.
- evt_ready_i, in, 1: host accepts event.
- evt_port_o, out, C_PORT_INDEX_WIDTH: port index of the offered event.
- pending_cnt_o, out, C_PORT_INDEX_WIDTH+1: count of pending ports.
- coal_thresh_i, in, C_PORT_INDEX_WIDTH+1: coalescing count threshold.
- coal_timeout_i, in, C_COAL_TIMER_WIDTH: coalescing timeout in cycles.
- irq_o, out, 1: level interrupt.

Function
REQ-006 pending[p] SHALL set on bufrx_pushed_i[p] & bufrx_opensock_i[p]; a push to an already-pending port SHALL merge.
REQ-007 pending[p] SHALL clear on an evt handshake for p, or when bufrx_opensock_i[p]=0; a set and a clear of the same bit in the same cycle SHALL leave it set.
REQ-008 pending_cnt_o SHALL be the registered popcount of pending, one cycle behind it.
REQ-009 The FSM SHALL have states IDLE, SCAN and OFFER, plus a round-robin pointer ptr.
REQ-010 IDLE SHALL go to SCAN when enable_i=1 and pending is nonzero.
REQ-011 SCAN SHALL examine one port per cycle. If pending[ptr]=1 it SHALL register evt_port_o=ptr and go to OFFER; otherwise ptr increments, wrapping C_MAX_UDP_PORTS-1 to 0.
REQ-012 SCAN SHALL return to IDLE when enable_i=0 or pending becomes all zero.
REQ-013 In OFFER, evt_valid_o=1 and evt_port_o SHALL hold stable until evt_ready_i=1.
REQ-014 An OFFER SHALL complete even if enable_i drops or the socket closes meanwhile.
REQ-015 On the OFFER handshake, ptr SHALL become evt_port_o+1 (with wrap) and the FSM SHALL go to IDLE.
REQ-016 The first-pending to evt_valid_o latency SHALL be at most C_MAX_UDP_PORTS+2 cycles.
REQ-017 Without coalescing, irq_o SHALL be a registered (pending_cnt_o != 0).

Reset
REQ-018 While rst_ni=0, all outputs SHALL be as follows, immediately and asynchronously:
- pending = 0, ptr = 0, FSM = IDLE.
- evt_valid_o = 0, evt_port_o = 0, pending_cnt_o = 0, irq_o = 0.
- coalescing timer = 0.
REQ-019 Reset during OFFER SHALL drop evt_valid_o with no handshake implied.

Configuration
REQ-020 Macro BUFRX_IRQ_COALESCE_EN SHALL select the interrupt behaviour:
- Defined: a timer counts while pending_cnt_o != 0 and stops counting at coal_timeout_i.
- Defined: irq_o rises when pending_cnt_o >= coal_thresh_i or the timer has reached coal_timeout_i.
- Defined: irq_o stays high until pending_cnt_o = 0, which also clears the timer.
- Defined: coal_thresh_i = 0 is treated as 1.
- Undefined: REQ-017 applies and coal_thresh_i and coal_timeout_i are ignored.

Structure
REQ-021 Package bufrx_sched_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SCAN=2'd1, OFFER=2'd2) and the default parameter constants.
REQ-022 Sub-module bufrx_irq_coalescer SHALL contain the timer and irq logic; it is instantiated in both builds, with a bypass path when the macro is undefined.

Verification (bench with C_MAX_UDP_PORTS=8)
REQ-023 Single event: ports 0-7 open, pulse push on port 5, evt_ready_i=1 -> evt_valid_o within 10 cycles with evt_port_o=5, then pending_cnt_o=0.
REQ-024 Round-robin: pushes on 2, 6 and 2, then a repeat push on 2 after its handshake -> event order 2, 6, 2.
REQ-025 Merge and close:
- Push port 3 twice -> exactly one event.
- Push port 4, then close it before the scan -> no event for port 4 and pending_cnt_o=0.
REQ-026 Backpressure: evt_ready_i=0 for 20 cycles during OFFER, while enable_i drops -> evt_port_o is stable and the event is delivered once ready rises.
REQ-027 Coalescing (macro defined), with coal_thresh_i=3 and coal_timeout_i=50:
- Two pushes -> irq_o rises 50 cycles after the first pending.
- Three pushes -> irq_o rises within 2 cycles.
- Macro undefined -> irq_o follows pending_cnt_o != 0.
REQ-028 Async reset: assert rst_ni mid-OFFER -> evt_valid_o=0 and pending_cnt_o=0 immediately.
